mont_modexp_ctrl: RTL and testbench
===================================

// Module: mont_modexp_ctrl
// PURPOSE
// - Left-to-right binary modular exponentiation controller: result = msg^exp mod n.
// - Sits directly upstream of the bit-serial Montgomery multiplier and drives it as a shared engine.
// - Issues the operand pairs for domain entry, square/multiply steps and domain exit.
// - Collects each Montgomery product before issuing the next operation.
// PARAMETERS
// - N_BITS  2048  operand/modulus width; R = 2^N_BITS. Must match the attached multiplier.
// - E_BITS  2048  exponent width; all E_BITS bits are processed, MSB first.
// PORTS
// - clk          in   1       clock
// - rst          in   1       synchronous, active-high reset
// - start        in   1       1-cycle request; accepted only while busy=0
// - msg          in   N_BITS  base; requirement msg < n
// - exp          in   E_BITS  exponent
// - n            in   N_BITS  modulus; odd, n > 1
// - r2           in   N_BITS  R^2 mod n, precomputed by software
// - result       out  N_BITS  msg^exp mod n; valid when done=1, held until next accept
// - done         out  1       1-cycle pulse
// - busy         out  1       high from accept until done
// - mul_start    out  1       1-cycle start pulse to the multiplier
// - mul_a        out  N_BITS  multiplier operand A
// - mul_b        out  N_BITS  multiplier operand B
// - mul_n        out  N_BITS  latched n
// - mul_result   in   N_BITS  Montgomery product A*B*R^-1 mod n
// - mul_done     in   1       1-cycle product-valid pulse
// BEHAVIOUR
// - Reset values: result=0, done=0, busy=0, mul_start=0, mul_a=0, mul_b=0, mul_n=0.
// - Internal state on reset: state=IDLE, bit counter=0.
// - Reset mid-operation aborts immediately; the multiplier shares rst.
// - Accept: start && state==IDLE latches msg, exp, n, r2, sets busy.
//   - start while busy is ignored; inputs may change after accept.
// - Each multiply op:
//   - Drive mul_a/mul_b and pulse mul_start for 1 cycle.
//   - Hold mul_a, mul_b and mul_n stable until mul_done.
//   - Capture mul_result on mul_done.
//   - Next mul_start may assert in the same cycle mul_done is seen (0-cycle gap).
// - States:
//   - IDLE   --accept-->  PRE_M   (first mul_start 1 cycle after accept)
//   - PRE_M   mont(msg, r2) -> Mbar.  On done -> PRE_X.
//   - PRE_X   mont(1, r2) -> X (= R mod n).  On done -> SQR, bit counter = E_BITS-1.
//   - SQR     mont(X, X) -> X.  On done: if exp[idx] -> MUL; else if idx==0 -> POST; else idx--, SQR.
//   - MUL     mont(X, Mbar) -> X.  On done: idx==0 -> POST, else idx--, SQR.
//   - POST    mont(X, 1) -> X.  On done -> DONE.
//   - DONE    result<=X, done=1 for 1 cycle, busy=0 -> IDLE.
// - Op count: 3 + E_BITS + popcount(exp).
//   - Non-constant-time by design; leading zeros are not skipped.
// - Bit counter: width clog2(E_BITS)+1. Decrement with no wrap; idx==0 terminates.
// - exp=0: only PRE_M, PRE_X and POST run no square/mul... correction: all E_BITS squares still run.
//   - X stays R mod n throughout; result=1.
// - mul_done outside a wait phase (spurious) is ignored.
// - No output combinationally depends on inputs; all outputs are registered.
// TESTING (N_BITS=32, E_BITS=8, real multiplier attached, bench computes r2)
// - msg=2, exp=10, n=1000003 -> result=1024, done pulse once, busy low after.
// - msg=3, exp=0, n=1000003 -> result=1; exactly 11 mul_start pulses (3+8+0).
// - msg=7, exp=1, n=0xFFFFFFFB -> result=7. Check mul_a/mul_b stable from each mul_start to mul_done.
// - msg=2, exp=255, n=1000003 -> result = bench pow(2,255) mod n; 19 mul_start pulses.
// - Second start pulsed while busy -> ignored. First result correct, no extra done.
// - rst asserted mid-SQR -> busy=0, done=0, mul_start=0 next cycle.
//   - A new start then completes correctly (msg=5, exp=3 -> 125).

Source files
------------

// File: rtl/mont_modexp_ctrl_if.sv
// Request/response and multiplier-engine bus of the modular exponentiation controller.
// The slave modport is the controller; master is the requester plus attached multiplier.
interface mont_modexp_ctrl_if #(
  parameter int unsigned N_BITS = 2048,
  parameter int unsigned E_BITS = 2048
);
  logic              start;
  logic [N_BITS-1:0] msg;
  logic [E_BITS-1:0] exp;
  logic [N_BITS-1:0] n;
  logic [N_BITS-1:0] r2;
  logic [N_BITS-1:0] result;
  logic              done;
  logic              busy;
  logic              mul_start;
  logic [N_BITS-1:0] mul_a;
  logic [N_BITS-1:0] mul_b;
  logic [N_BITS-1:0] mul_n;
  logic [N_BITS-1:0] mul_result;
  logic              mul_done;

  modport slave (
    input  start, msg, exp, n, r2, mul_result, mul_done,
    output result, done, busy, mul_start, mul_a, mul_b, mul_n
  );

  modport master (
    output start, msg, exp, n, r2, mul_result, mul_done,
    input  result, done, busy, mul_start, mul_a, mul_b, mul_n
  );
endinterface

// File: rtl/mont_modexp_ctrl.sv
// Left-to-right binary modular exponentiation (msg^exp mod n) sequencing a shared
// Montgomery multiplier: domain entry, square/multiply per exponent bit, domain exit.
module mont_modexp_ctrl #(
  parameter int unsigned N_BITS = 2048,
  parameter int unsigned E_BITS = 2048
) (
  input logic              clk,
  input logic              rst,
  mont_modexp_ctrl_if.slave bus
);
  localparam int unsigned IW = $clog2(E_BITS);
  localparam logic [N_BITS-1:0] ONE = N_BITS'(1);

  typedef enum logic [2:0] {IDLE, PRE_M, PRE_X, SQR, MUL, POST, DONE} state_t;

  state_t            r_state;
  logic [IW:0]       r_idx;
  logic [E_BITS-1:0] r_exp;
  logic [N_BITS-1:0] r_r2;
  logic [N_BITS-1:0] r_mbar;
  logic [N_BITS-1:0] r_x;

  logic w_ack;
  logic w_bit;
  logic w_last;

  // A product cannot be valid in the cycle its own start is still being presented.
  assign w_ack  = bus.mul_done && !bus.mul_start;
  assign w_bit  = r_exp[r_idx[IW-1:0]];
  assign w_last = (r_idx == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_exp         <= '0;
      r_r2          <= '0;
      r_mbar        <= '0;
      r_x           <= '0;
      bus.result    <= '0;
      bus.done      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.mul_start <= 1'b0;
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
      bus.mul_n     <= '0;
    end else begin
      bus.done      <= 1'b0;
      bus.mul_start <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          // msg is consumed straight into operand A, which stays held until the first product.
          r_exp         <= bus.exp;
          r_r2          <= bus.r2;
          bus.mul_n     <= bus.n;
          bus.mul_a     <= bus.msg;
          bus.mul_b     <= bus.r2;
          bus.mul_start <= 1'b1;
          bus.busy      <= 1'b1;
          r_state       <= PRE_M;
        end
        PRE_M: if (w_ack) begin
          r_mbar        <= bus.mul_result;
          bus.mul_a     <= ONE;
          bus.mul_b     <= r_r2;
          bus.mul_start <= 1'b1;
          r_state       <= PRE_X;
        end
        PRE_X: if (w_ack) begin
          r_idx         <= (IW+1)'(E_BITS-1);
          bus.mul_a     <= bus.mul_result;
          bus.mul_b     <= bus.mul_result;
          bus.mul_start <= 1'b1;
          r_state       <= SQR;
        end
        SQR: if (w_ack) begin
          bus.mul_a     <= bus.mul_result;
          bus.mul_start <= 1'b1;
          if (w_bit) begin
            bus.mul_b <= r_mbar;
            r_state   <= MUL;
          end else if (w_last) begin
            bus.mul_b <= ONE;
            r_state   <= POST;
          end else begin
            r_idx     <= r_idx - (IW+1)'(1);
            bus.mul_b <= bus.mul_result;
            r_state   <= SQR;
          end
        end
        MUL: if (w_ack) begin
          bus.mul_a     <= bus.mul_result;
          bus.mul_start <= 1'b1;
          if (w_last) begin
            bus.mul_b <= ONE;
            r_state   <= POST;
          end else begin
            r_idx     <= r_idx - (IW+1)'(1);
            bus.mul_b <= bus.mul_result;
            r_state   <= SQR;
          end
        end
        POST: if (w_ack) begin
          r_x     <= bus.mul_result;
          r_state <= DONE;
        end
        DONE: begin
          bus.result <= r_x;
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Bench for mont_modexp_ctrl: behavioural Montgomery multiplier with random latency,
// per-cycle compare against a pow/popcount reference, directed and random exponentiations.
module tb_mont_modexp_ctrl;
  localparam int unsigned NB = 32;
  localparam int unsigned EB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mont_modexp_ctrl_if #(.N_BITS(NB), .E_BITS(EB)) bus ();
  mont_modexp_ctrl #(.N_BITS(NB), .E_BITS(EB)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_total = 0;
  int n_bad   = 0;
  bit spur    = 1'b0;

  // a*b*2^-NB mod n: reduce the product, then halve modulo n NB times.
  function automatic longint unsigned mont(longint unsigned a, longint unsigned b, longint unsigned n);
    longint unsigned p;
    p = (a * b) % n;
    for (int i = 0; i < int'(NB); i++) p = p[0] ? (p + n) >> 1 : p >> 1;
    return p;
  endfunction

  function automatic longint unsigned r2_of(longint unsigned n);
    longint unsigned r;
    r = (64'h1 << NB) % n;
    return (r * r) % n;
  endfunction

  function automatic longint unsigned modpow(longint unsigned m, int unsigned e, longint unsigned n);
    longint unsigned r;
    r = 1 % n;
    for (int unsigned i = 0; i < e; i++) r = (r * m) % n;
    return r;
  endfunction

  function automatic int popcnt(logic [EB-1:0] v);
    int c = 0;
    for (int i = 0; i < int'(EB); i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Multiplier stand-in: result after 1..4 cycles, shares rst, optional stray done in idle.
  bit              mp_pend = 1'b0;
  int              mp_cnt  = 0;
  logic [NB-1:0]   mp_prod = '0;
  always @(posedge clk) begin
    #2;
    bus.mul_done = 1'b0;
    if (rst) mp_pend = 1'b0;
    else if (mp_pend) begin
      if (mp_cnt <= 1) begin
        bus.mul_done   = 1'b1;
        bus.mul_result = mp_prod;
        mp_pend        = 1'b0;
      end else mp_cnt--;
    end else if (spur && !bus.busy) begin
      bus.mul_done   = 1'b1;
      bus.mul_result = $urandom;
    end
    if (!rst && bus.mul_start) begin
      mp_pend = 1'b1;
      mp_cnt  = $urandom_range(1, 4);
      mp_prod = NB'(mont(bus.mul_a, bus.mul_b, bus.mul_n));
    end
  end

  // Reference model state (owned by the main thread via tick).
  bit            m_busy = 1'b0, m_pend = 1'b0, m_fin = 1'b0;
  int            m_left = 0;
  logic [NB-1:0] m_res = '0, h_a = '0, h_b = '0, h_n = '0;
  int            ms_count = 0, done_count = 0;

  task automatic tick();
    bit exp_ms, exp_done;
    @(posedge clk);
    #1;
    exp_ms   = 1'b0;
    exp_done = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_pend = 1'b0; m_fin = 1'b0;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_mul_start", bus.mul_start, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_mul_a", bus.mul_a, 0);
      chk("rst_mul_b", bus.mul_b, 0);
      chk("rst_mul_n", bus.mul_n, 0);
    end else begin
      if (!m_busy && bus.start) begin
        m_busy = 1'b1; m_pend = 1'b1;
        m_left = 3 + int'(EB) + popcnt(bus.exp);
        m_res  = NB'(modpow(bus.msg, bus.exp, bus.n));
        h_n    = bus.n;
        exp_ms = 1'b1;
      end else if (m_busy && m_pend && bus.mul_done) begin
        m_left--;
        if (m_left == 0) begin m_pend = 1'b0; m_fin = 1'b1; end
        else exp_ms = 1'b1;
      end else if (m_fin) begin
        exp_done = 1'b1; m_busy = 1'b0; m_fin = 1'b0;
      end
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, exp_done);
      chk("mul_start", bus.mul_start, exp_ms);
      if (exp_done) chk("result", bus.result, m_res);
      if (bus.mul_start) begin
        ms_count++;
        h_a = bus.mul_a;
        h_b = bus.mul_b;
      end else if (m_pend) begin
        chk("hold_mul_a", bus.mul_a, h_a);
        chk("hold_mul_b", bus.mul_b, h_b);
      end
      if (m_busy) chk("mul_n", bus.mul_n, h_n);
      if (bus.done) done_count++;
    end
    @(negedge clk);
  endtask

  task automatic launch(input logic [NB-1:0] msg, input logic [EB-1:0] e, input logic [NB-1:0] n);
    bus.msg   = msg;
    bus.exp   = e;
    bus.n     = n;
    bus.r2    = NB'(r2_of(n));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.msg   = $urandom;
    bus.exp   = EB'($urandom);
    bus.n     = $urandom;
    bus.r2    = $urandom;
  endtask

  task automatic wait_done(input string name, output logic [NB-1:0] res);
    int cyc = 0;
    while (!bus.done && cyc < 2000) begin
      tick();
      cyc++;
    end
    if (!bus.done) begin
      n_total++;
      n_bad++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
    res = bus.result;
    tick();
  endtask

  task automatic run(input string name, input logic [NB-1:0] msg, input logic [EB-1:0] e,
                     input logic [NB-1:0] n, output logic [NB-1:0] res, output int starts);
    int s0;
    s0 = ms_count;
    launch(msg, e, n);
    wait_done(name, res);
    starts = ms_count - s0;
  endtask

  initial begin
    logic [NB-1:0] res, n, msg;
    logic [EB-1:0] e;
    int starts, s0, d0;

    bus.start = 1'b0;
    bus.msg = '0; bus.exp = '0; bus.n = '0; bus.r2 = '0;
    bus.mul_result = '0;
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("pin_mont_R", mont(1, r2_of(1000003), 1000003), 954414);
    chk("pin_pow_2_10", modpow(2, 10, 1000003), 1024);

    run("t_2_10", 2, 10, 1000003, res, starts);
    chk("t_2_10_result", res, 1024);
    chk("t_2_10_starts", starts, 3 + 8 + 2);
    chk("t_2_10_busy_after", bus.busy, 0);

    spur = 1'b1; repeat (3) tick(); spur = 1'b0;
    run("t_exp0", 3, 0, 1000003, res, starts);
    chk("t_exp0_result", res, 1);
    chk("t_exp0_starts", starts, 11);

    run("t_7_1", 7, 1, 32'hFFFF_FFFB, res, starts);
    chk("t_7_1_result", res, 7);
    chk("t_7_1_starts", starts, 12);

    run("t_2_255", 2, 8'hFF, 1000003, res, starts);
    chk("t_2_255_result", res, modpow(2, 255, 1000003));
    chk("t_2_255_starts", starts, 19);

    // Start pulsed while busy must not disturb the running job.
    d0 = done_count;
    launch(2, 10, 1000003);
    repeat (5) tick();
    bus.msg = 9; bus.exp = 200; bus.n = 1000003; bus.r2 = NB'(r2_of(1000003));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("t_busy_start", res);
    repeat (40) tick();
    chk("t_busy_start_result", res, 1024);
    chk("t_busy_start_dones", done_count - d0, 1);

    // Reset in the middle of a square step.
    s0 = ms_count;
    launch(2, 8'hFF, 1000003);
    for (int i = 0; i < 200 && (ms_count - s0) < 3; i++) tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t_rst_busy", bus.busy, 0);
    chk("t_rst_done", bus.done, 0);
    chk("t_rst_mul_start", bus.mul_start, 0);
    tick();
    run("t_after_rst", 5, 3, 1000003, res, starts);
    chk("t_after_rst_result", res, 125);

    for (int k = 0; k < 30; k++) begin
      n = $urandom | 32'h1;
      if (n < 3) n = 3;
      msg = NB'($urandom % n);
      case (k % 5)
        0: e = '0;
        1: e = '1;
        default: e = EB'($urandom);
      endcase
      if (k % 4 == 0) begin spur = 1'b1; tick(); tick(); spur = 1'b0; end
      run("t_rand", msg, e, n, res, starts);
      chk("t_rand_result", res, modpow(msg, e, n));
      chk("t_rand_starts", starts, 3 + int'(EB) + popcnt(e));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
